// File: rtl/spi_regfile_pkg.sv
// Shared types and default sizing for the SPI data register file.
package spi_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_write_arb.sv
// Resolves the host and SPI write ports: range check, same-address collision, port 2 priority.
// Purely combinational; writes are suppressed entirely while the clear sweep blocks the file.
module regfile_write_arb
  import spi_regfile_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          blk,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic          wr2,
  input  logic [AW-1:0] addr2,
  output logic          we1,
  output logic          we2,
  output logic          col,
  output logic          err
);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic ok1;
  logic ok2;

  always_comb begin
    ok1 = ({1'b0, addr1} < DEPTH_V);
    ok2 = ({1'b0, addr2} < DEPTH_V);
    col = ~blk & wr1 & wr2 & ok1 & ok2 & (addr1 == addr2);
    // Port 2 wins a same-address write, so port 1 is dropped rather than overwritten.
    we1 = ~blk & wr1 & ok1 & ~col;
    we2 = ~blk & wr2 & ok2;
    err = ~blk & ((wr1 & ~ok1) | (wr2 & ~ok2));
  end

endmodule

// File: rtl/spi_data_regfile.sv
// Dual-write, single-read register file with per-entry valid bits and a one-entry-per-cycle clear sweep.
// Read data lands one cycle after rd_en; hold_ctrl freezes the output and drops reads, the sweep ignores all accesses.
module spi_data_regfile
  import spi_regfile_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] IN1,
  input  logic              WR1,
  input  logic [AW-1:0]     addr1,
  input  logic [DATA_W-1:0] IN2,
  input  logic              WR2,
  input  logic [AW-1:0]     addr2,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic              hold_ctrl,
  input  logic              clr_start,
  output logic [DATA_W-1:0] OUT_DATA_REGISTER,
  output logic              out_valid,
  output logic              collision,
  output logic              addr_err,
  output logic              busy
);

  localparam logic [AW:0]   DEPTH_V = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              col_q, col_d;
  logic              err_q, err_d;

  logic we1, we2, arb_col, arb_err, rd_ok, clr_en;

  regfile_write_arb #(.DEPTH(DEPTH)) u_arb (
    .blk   (state_q == CLEAR),
    .wr1   (WR1),
    .addr1 (addr1),
    .wr2   (WR2),
    .addr2 (addr2),
    .we1   (we1),
    .we2   (we2),
    .col   (arb_col),
    .err   (arb_err)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    col_d   = 1'b0;
    err_d   = 1'b0;
    clr_en  = 1'b0;
    rd_ok   = ({1'b0, rd_addr} < DEPTH_V);
    unique case (state_q)
      IDLE: begin
        col_d = arb_col;
        err_d = arb_err | (rd_en & ~rd_ok);
        // Reads sample storage before this edge's writes, giving read-before-write.
        if (rd_en && rd_ok && !hold_ctrl) begin
          out_d = valid_q[rd_addr] ? mem_q[rd_addr] : '0;
          vld_d = 1'b1;
        end
        if (clr_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (ptr_q == LAST) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      col_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      col_q   <= col_d;
      err_q   <= err_d;
      if (clr_en) begin
        valid_q[ptr_q] <= 1'b0;
      end else begin
        if (we1) valid_q[addr1] <= 1'b1;
        if (we2) valid_q[addr2] <= 1'b1;
      end
    end
  end

  // Data words carry no reset; the valid bits alone guarantee zero reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) begin
        mem_q[ptr_q] <= '0;
      end else begin
        if (we1) mem_q[addr1] <= IN1;
        if (we2) mem_q[addr2] <= IN2;
      end
    end
  end

  assign OUT_DATA_REGISTER = out_q;
  assign out_valid         = vld_q;
  assign collision         = col_q;
  assign addr_err          = err_q;
  assign busy              = (state_q == CLEAR);

endmodule

// File: doc/spi_data_regfile.md
SPI_DATA_REGFILE -- requirements
Module: spi_data_regfile

Interface
REQ-001 Parameter DATA_W, 32, data word width in bits (legal range 8..64).
REQ-002 Parameter DEPTH, 256, number of entries (legal range 2..256, need not be a power of 2).
REQ-003 Localparam AW = $clog2(DEPTH); it is not overridable.
REQ-004 The clock port SHALL be `clk`, input, 1 bit, and all state SHALL update on its rising edge.
REQ-005 The reset port SHALL be `rst`, input, 1 bit, synchronous and active-high.
REQ-006 Port `IN1`, input, DATA_W: write data for port 1 (host side).
REQ-007 Port `WR1`, input, 1: write enable for port 1.
REQ-008 Port `addr1`, input, AW: write address for port 1.
REQ-009 Port `IN2`, input, DATA_W: write data for port 2 (SPI receive side).
REQ-010 Port `WR2`, input, 1: write enable for port 2.
REQ-011 Port `addr2`, input, AW: write address for port 2.
REQ-012 Port `rd_en`, input, 1: read request.
REQ-013 Port `rd_addr`, input, AW: read address.
REQ-014 Port `hold_ctrl`, input, 1: freezes the output register.
REQ-015 Port `clr_start`, input, 1: starts a clear sweep.
REQ-016 Port `OUT_DATA_REGISTER`, output, DATA_W: registered read data.
REQ-017 Port `out_valid`, output, 1: one-cycle pulse marking new read data.
REQ-018 Port `collision`, output, 1: one-cycle pulse for a same-address dual write.
REQ-019 Port `addr_err`, output, 1: one-cycle pulse for any access with an address >= DEPTH.
REQ-020 Port `busy`, output, 1: high while the clear sweep is running.

Function
REQ-021 Storage SHALL be DEPTH x DATA_W words, with one valid bit per entry.
REQ-022 Write, port 1: WR1=1 and addr1<DEPTH SHALL store IN1 at the cycle edge and set that entry's valid bit.
REQ-023 Write, port 2: the same rule as REQ-022 applied to WR2/addr2/IN2.
REQ-024 Both ports writing different addresses in the same cycle SHALL both take effect.
REQ-025 Both ports writing the same address in the same cycle: IN2 SHALL win, and `collision`=1 in the next cycle only.
REQ-026 Read: rd_en=1 at cycle n SHALL give OUT_DATA_REGISTER = entry value and out_valid=1 at cycle n+1.
REQ-027 A read of an entry whose valid bit is clear SHALL return 0 and still pulse out_valid.
REQ-028 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-029 hold_ctrl=1 SHALL keep OUT_DATA_REGISTER unchanged and force out_valid=0.
REQ-030 A read requested while hold_ctrl=1 SHALL be dropped, not queued.
REQ-031 Any enabled access (WR1, WR2 or rd_en) with an address >= DEPTH SHALL be ignored and pulse `addr_err` in the next cycle.
REQ-032 An out-of-range read SHALL leave OUT_DATA_REGISTER unchanged.
REQ-033 The FSM SHALL have two states, IDLE and CLEAR.
REQ-034 IDLE -> CLEAR on clr_start=1; the clear pointer SHALL load 0 and busy=1 from the next cycle.
REQ-035 In CLEAR, one entry per cycle SHALL have its data and valid bit zeroed, and the pointer SHALL increment.
REQ-036 CLEAR -> IDLE after pointer DEPTH-1 is cleared; the sweep SHALL take exactly DEPTH cycles, then busy=0.
REQ-037 During CLEAR, WR1, WR2 and rd_en SHALL be ignored, with no collision or addr_err pulses.
REQ-038 During CLEAR, OUT_DATA_REGISTER SHALL hold its value.
REQ-039 clr_start asserted while busy=1 SHALL be ignored; the sweep does not restart.

Reset
REQ-040 rst=1 SHALL, at the next edge, clear all valid bits and set OUT_DATA_REGISTER=0.
REQ-041 rst=1 SHALL also set out_valid, collision, addr_err and busy to 0, the FSM to IDLE, and the pointer to 0.
REQ-042 Storage data is not cleared by reset; reads are guaranteed 0 through the valid bits.
REQ-043 rst during CLEAR SHALL abort the sweep immediately.
REQ-044 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-045 Package spi_regfile_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the default DATA_W/DEPTH constants.
REQ-046 One sub-module, regfile_write_arb, SHALL resolve the two write ports: priority, collision detect and range check.

Verification
REQ-047 Reset, then read 8'h0A -> OUT_DATA_REGISTER=0, out_valid=1 one cycle later.
REQ-048 WR2 write 32'hABB1ABCD @8'h2A, then read 8'h2A -> 32'hABB1ABCD at latency 1.
REQ-049 WR1 writes 32'hAAA1AACD @8'h0A while WR2 writes 32'hCCD1ABCD @8'h0A -> collision pulse; a later read of 8'h0A returns 32'hCCD1ABCD.
REQ-050 Read 8'h2A with hold_ctrl=1 -> output unchanged and out_valid=0; repeat with hold_ctrl=0 -> 32'hABB1ABCD.
REQ-051 DEPTH=200: write and read addr 8'hC8 -> addr_err pulse each time, no storage change.
REQ-052 clr_start, then WR1 @8'h5A during the sweep -> busy high for exactly DEPTH cycles; afterwards 8'h5A and 8'h2A both read 0.
